// File: rtl/bus_arbiter_pkg.sv
// Shared definitions for the bus arbiter.
//   state_t      : FSM state encoding (IDLE / GRANT / TURN)
//   DEF_*        : default parameter values for the arbiter instance
package bus_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_TURN  = 2'd2
  } state_t;

  localparam int DEF_N_REQ    = 4;
  localparam int DEF_IDX_W    = 2;
  localparam int DEF_MAX_HOLD = 8;

endpackage

// File: rtl/bus_arbiter_rr_select.sv
// Combinational round-robin priority picker.
//   req        : request vector, one bit per requester
//   last_owner : index of the previous bus owner; search starts one above it
//   winner     : first requesting index found from last_owner+1 with wrap
//   any_req    : high when any request bit is set (winner meaningful only then)
module rr_select #(
  parameter int N_REQ = 4,
  parameter int IDX_W = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] last_owner,
  output logic [IDX_W-1:0] winner,
  output logic             any_req
);

  logic [2*N_REQ-1:0] dbl;
  logic [N_REQ-1:0]   rot;
  int                 start;
  int                 pos;

  // Rotate the request vector so the search start sits at bit 0, then take
  // the lowest set bit and map it back to an absolute index.
  always_comb begin
    start = (int'(last_owner) + 1) % N_REQ;
    dbl   = {req, req} >> start;
    rot   = dbl[N_REQ-1:0];
    pos   = 0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (rot[i]) pos = i;
    end
    winner  = IDX_W'((start + pos) % N_REQ);
    any_req = |req;
  end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin arbiter driving the tri-state buffer enables of a shared bus.
//   clk        : system clock, rising edge
//   reset      : asynchronous, active-high reset
//   req        : level requests, held by each requester until it is done
//   bus_enable : one-hot (or zero) buffer enables, registered
//   owner      : index of the current grantee, meaningful while bus_busy=1
//   bus_busy   : high while a bus_enable bit is high
//   turnaround : high during the single dead cycle between two owners
//   dbg_state  : current FSM state
//
// Handshake: a requester raises req and keeps it high while it wants the bus;
// it owns the bus on every cycle its bus_enable bit is high and releases it by
// dropping req. A release is always followed by one all-off cycle before the
// next owner is enabled, so two buffers never drive the bus together.
module bus_arbiter
  import bus_arbiter_pkg::*;
#(
  parameter int N_REQ    = DEF_N_REQ,
  parameter int IDX_W    = DEF_IDX_W,
  parameter int MAX_HOLD = DEF_MAX_HOLD
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] bus_enable,
  output logic [IDX_W-1:0] owner,
  output logic             bus_busy,
  output logic             turnaround,
  output state_t           dbg_state
);

  localparam int CNT_W = (MAX_HOLD < 2) ? 1 : $clog2(MAX_HOLD + 1);
  localparam logic [CNT_W-1:0] HOLD_MAX  = CNT_W'(MAX_HOLD);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'((MAX_HOLD > 0) ? MAX_HOLD - 1 : 0);

  state_t           state, state_n;
  logic [IDX_W-1:0] last_owner, last_owner_n;
  logic [CNT_W-1:0] hold_cnt, hold_cnt_n;
  logic [N_REQ-1:0] bus_enable_n;
  logic [IDX_W-1:0] owner_n;
  logic             bus_busy_n;
  logic             turnaround_n;

  logic [IDX_W-1:0] winner;
  logic             any_req;
  logic             own_req;
  logic             other_req;
  logic             hold_expired;
  logic             release_now;

  rr_select #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_rr_select (
    .req        (req),
    .last_owner (last_owner),
    .winner     (winner),
    .any_req    (any_req)
  );

  // In GRANT bus_enable is exactly onehot(owner), so masking req with it
  // separates the owner's request from everyone else's.
  assign own_req   = |(req & bus_enable);
  assign other_req = |(req & ~bus_enable);

  // The counter saturates at MAX_HOLD; treating the saturated value as
  // expired too lets a late-arriving request still preempt a long holder.
  assign hold_expired = (MAX_HOLD != 0) &&
                        ((hold_cnt == HOLD_LAST) || (hold_cnt == HOLD_MAX));
  assign release_now  = !own_req || (hold_expired && other_req);

  always_comb begin
    state_n      = state;
    last_owner_n = last_owner;
    hold_cnt_n   = hold_cnt;
    bus_enable_n = bus_enable;
    owner_n      = owner;
    bus_busy_n   = bus_busy;
    turnaround_n = 1'b0;
    case (state)
      ST_IDLE, ST_TURN: begin
        if (any_req) begin
          state_n      = ST_GRANT;
          bus_enable_n = N_REQ'(1) << winner;
          owner_n      = winner;
          bus_busy_n   = 1'b1;
          hold_cnt_n   = '0;
        end else begin
          state_n      = ST_IDLE;
          bus_enable_n = '0;
          bus_busy_n   = 1'b0;
        end
      end
      ST_GRANT: begin
        if (release_now) begin
          state_n      = ST_TURN;
          bus_enable_n = '0;
          bus_busy_n   = 1'b0;
          turnaround_n = 1'b1;
          last_owner_n = owner;
          hold_cnt_n   = '0;
        end else if (hold_cnt != HOLD_MAX) begin
          hold_cnt_n = hold_cnt + 1'b1;
        end
      end
      default: begin
        state_n      = ST_IDLE;
        bus_enable_n = '0;
        bus_busy_n   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      last_owner <= IDX_W'(N_REQ - 1);
      hold_cnt   <= '0;
      bus_enable <= '0;
      owner      <= '0;
      bus_busy   <= 1'b0;
      turnaround <= 1'b0;
    end else begin
      state      <= state_n;
      last_owner <= last_owner_n;
      hold_cnt   <= hold_cnt_n;
      bus_enable <= bus_enable_n;
      owner      <= owner_n;
      bus_busy   <= bus_busy_n;
      turnaround <= turnaround_n;
    end
  end

  assign dbg_state = state;

  a_onehot : assert property (@(posedge clk) disable iff (reset) $onehot0(bus_enable));
  a_busy   : assert property (@(posedge clk) disable iff (reset) bus_busy == (|bus_enable));
  a_excl   : assert property (@(posedge clk) disable iff (reset) !(bus_busy && turnaround));

endmodule

// File: tb/tb_bus_arbiter.sv
// Bench for bus_arbiter: three instances (MAX_HOLD = 0, 8, 2) share clk,
// reset and req; each scenario selects which one is scored against a
// behavioural model through an expected-value queue.
module tb_bus_arbiter;
  import bus_arbiter_pkg::*;

  localparam int W = 10;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  logic [3:0] req;
  always #5 clk = ~clk;

  logic [3:0] en_d   [3];
  logic [1:0] own_d  [3];
  logic       busy_d [3];
  logic       turn_d [3];
  state_t     st_d   [3];

  bus_arbiter #(.N_REQ(4), .IDX_W(2), .MAX_HOLD(0)) u_dut0 (
    .clk(clk), .reset(reset), .req(req), .bus_enable(en_d[0]), .owner(own_d[0]),
    .bus_busy(busy_d[0]), .turnaround(turn_d[0]), .dbg_state(st_d[0]));
  bus_arbiter #(.N_REQ(4), .IDX_W(2), .MAX_HOLD(8)) u_dut8 (
    .clk(clk), .reset(reset), .req(req), .bus_enable(en_d[1]), .owner(own_d[1]),
    .bus_busy(busy_d[1]), .turnaround(turn_d[1]), .dbg_state(st_d[1]));
  bus_arbiter #(.N_REQ(4), .IDX_W(2), .MAX_HOLD(2)) u_dut2 (
    .clk(clk), .reset(reset), .req(req), .bus_enable(en_d[2]), .owner(own_d[2]),
    .bus_busy(busy_d[2]), .turnaround(turn_d[2]), .dbg_state(st_d[2]));

  int sel;
  int n_tests = 0;
  int n_fail  = 0;

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] pack(input logic [3:0] en, input logic [1:0] own,
                                        input logic busy, input logic turn,
                                        input logic [1:0] st);
    return {en, busy ? own : 2'b00, busy, turn, st};
  endfunction

  function automatic logic [W-1:0] obs();
    return pack(en_d[sel], own_d[sel], busy_d[sel], turn_d[sel], 2'(st_d[sel]));
  endfunction

  // ---------------- reference model ----------------
  int m_st, m_last, m_owner, m_cnt, mh, g_age;
  logic m_turn;

  task automatic model_reset();
    m_st = 0; m_last = 3; m_owner = 0; m_cnt = 0; g_age = 0; m_turn = 1'b0;
  endtask

  function automatic int rr_pick(input logic [3:0] r, input int last);
    for (int i = 1; i <= 4; i++) begin
      if (r[(last + i) % 4]) return (last + i) % 4;
    end
    return -1;
  endfunction

  task automatic model_step(input logic [3:0] r);
    int   w;
    logic other, rel;
    if (m_st == 1) begin
      other = |(r & ~(4'b0001 << m_owner));
      rel   = !r[m_owner] || (mh != 0 && m_cnt >= mh - 1 && other);
      if (rel) begin
        m_last = m_owner; m_cnt = 0; m_st = 2; g_age = 0; m_turn = 1'b1;
      end else begin
        m_cnt = (m_cnt < mh) ? m_cnt + 1 : mh;
        g_age++;
        m_turn = 1'b0;
      end
    end else begin
      m_turn = 1'b0;
      w = rr_pick(r, m_last);
      if (w >= 0) begin
        m_st = 1; m_owner = w; m_cnt = 0; g_age = 1;
      end else begin
        m_st = 0;
      end
    end
  endtask

  function automatic logic [W-1:0] model_pack();
    logic [3:0] en;
    en = (m_st == 1) ? (4'b0001 << m_owner) : 4'b0000;
    return pack(en, 2'(m_owner), m_st == 1, m_turn, 2'(m_st));
  endfunction

  // ---------------- driver tasks ----------------
  task automatic step(input logic [3:0] r);
    @(negedge clk);
    req = r;
    model_step(r);
    exp_q.push_back(model_pack());
    @(posedge clk);
    #1;
    chk("sb", obs(), exp_q.pop_front());
  endtask

  task automatic do_reset(input int s, input int hold);
    @(negedge clk);
    sel = s; mh = hold;
    reset = 1'b1; req = 4'b0000;
    #1;
    chk("rst_out", obs(), {W{1'b0}});
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    exp_q.delete();
  endtask

  // Bus-safety invariants on every instance, sampled mid-cycle.
  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      chk("onehot0", ($countones(en_d[k]) <= 1), 1);
      chk("busy_eq", busy_d[k], |en_d[k]);
      chk("busy_turn_excl", busy_d[k] && turn_d[k], 0);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int got_order[$];
    int turns, lead, cnt_en;
    logic prev_busy, raised;
    logic [3:0] r;
    logic [3:0] seq_en [20];
    logic       seq_tn [20];

    reset = 1'b1; req = 4'b0000; sel = 0; mh = 0;
    model_reset();
    #2;
    for (int k = 0; k < 3; k++) begin
      sel = k;
      chk("reset_state", obs(), {W{1'b0}});
    end

    // Round robin, no preemption: each owner drops after two grant cycles.
    do_reset(0, 0);
    turns = 0; prev_busy = 1'b0;
    for (int c = 0; c < 16; c++) begin
      r = 4'b1111;
      if (m_st == 1 && g_age == 2) r[m_owner] = 1'b0;
      step(r);
      if (busy_d[0] && !prev_busy) got_order.push_back(int'(own_d[0]));
      if (turn_d[0]) turns++;
      prev_busy = busy_d[0];
    end
    chk("rr_count", (got_order.size() >= 5), 1);
    chk("rr_order0", (got_order.size() > 0) ? got_order[0] : 99, 0);
    chk("rr_order1", (got_order.size() > 1) ? got_order[1] : 99, 1);
    chk("rr_order2", (got_order.size() > 2) ? got_order[2] : 99, 2);
    chk("rr_order3", (got_order.size() > 3) ? got_order[3] : 99, 3);
    chk("rr_order4", (got_order.size() > 4) ? got_order[4] : 99, 0);
    chk("rr_turns", turns, 5);

    // Preemption with MAX_HOLD=8: req2 joins in the third grant cycle.
    do_reset(1, 8);
    raised = 1'b0;
    for (int c = 0; c < 20; c++) begin
      if (m_st == 1 && m_owner == 0 && g_age >= 3) raised = 1'b1;
      step(raised ? 4'b0101 : 4'b0001);
      seq_en[c] = en_d[1];
      seq_tn[c] = turn_d[1];
    end
    lead = 0;
    while (lead < 20 && seq_en[lead] == 4'b0001) lead++;
    chk("pre_hold_len", lead, 8);
    chk("pre_gap_en", seq_en[8], 4'b0000);
    chk("pre_gap_turn", seq_tn[8], 1);
    chk("pre_next_en", seq_en[9], 4'b0100);

    // Lone holder with MAX_HOLD=2 is never preempted.
    do_reset(2, 2);
    cnt_en = 0; turns = 0;
    for (int c = 0; c < 20; c++) begin
      step(4'b1000);
      if (en_d[2] == 4'b1000) cnt_en++;
      if (turn_d[2]) turns++;
    end
    chk("lone_en_cycles", cnt_en, 20);
    chk("lone_turns", turns, 0);

    // Handover: req1 drops while req0 rises on the same edge.
    do_reset(0, 0);
    step(4'b0010);
    chk("ho_grant1", en_d[0], 4'b0010);
    step(4'b0010);
    step(4'b0001);
    chk("ho_gap_en", en_d[0], 4'b0000);
    chk("ho_gap_turn", turn_d[0], 1);
    step(4'b0001);
    chk("ho_grant0", en_d[0], 4'b0001);

    // Asynchronous reset in the middle of a grant.
    do_reset(0, 0);
    step(4'b0010);
    step(4'b0010);
    #2;
    reset = 1'b1;
    #1;
    chk("midrst_out", obs(), {W{1'b0}});
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    exp_q.delete();
    step(4'b0010);
    chk("midrst_en", en_d[0], 4'b0010);
    chk("midrst_owner", own_d[0], 1);

    // Random request traffic on every instance.
    for (int k = 0; k < 3; k++) begin
      do_reset(k, (k == 0) ? 0 : ((k == 1) ? 8 : 2));
      for (int c = 0; c < 150; c++) step(4'($urandom_range(0, 15)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
